// File: rtl/range_tracker.sv
// range_tracker: tracks min, max, range and a saturating sample count of a
// qualified data stream between a go and a finish command. Results hold after
// the run ends; error cases are reported with a 2-bit code.
// Build option: define RANGE_TRACKER_SIGNED_EN for two's complement samples.
module range_tracker #(
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [WIDTH:0]       range_out,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 cnt_sat,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code
);

  typedef enum logic [1:0] {S_IDLE, S_READING, S_DONE, S_ERROR} state_t;

  localparam logic [1:0]           ERR_NONE     = 2'b00;
  localparam logic [1:0]           ERR_NO_START = 2'b01;
  localparam logic [1:0]           ERR_EMPTY    = 2'b10;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  state_t               state_r, state_next;
  logic [WIDTH-1:0]     min_r, min_next;
  logic [WIDTH-1:0]     max_r, max_next;
  logic [CNT_WIDTH-1:0] count_r, count_next;
  logic                 sat_r, sat_next;
  logic [1:0]           err_r, err_next;

  logic                 start;
  logic                 below_min;
  logic                 above_max;
  logic [CNT_WIDTH-1:0] cnt_plus;
  logic [WIDTH:0]       min_ext;
  logic [WIDTH:0]       max_ext;

  // go without finish starts a run from any state, including a restart mid-run
  assign start    = go & ~finish;
  assign cnt_plus = count_r + 1'b1;

`ifdef RANGE_TRACKER_SIGNED_EN
  assign below_min = $signed(data_in) < $signed(min_r);
  assign above_max = $signed(data_in) > $signed(max_r);
  assign min_ext   = {min_out[WIDTH-1], min_out};
  assign max_ext   = {max_out[WIDTH-1], max_out};
`else
  assign below_min = data_in < min_r;
  assign above_max = data_in > max_r;
  assign min_ext   = {1'b0, min_out};
  assign max_ext   = {1'b0, max_out};
`endif

  // Next-state and datapath update for the run controller
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state_r;
    min_next   = min_r;
    max_next   = max_r;
    count_next = count_r;
    sat_next   = sat_r;
    err_next   = err_r;

    if (start && !(state_r == S_READING && finish)) begin
      // Fresh run; a valid sample in the go cycle is the first sample
      state_next = S_READING;
      err_next   = ERR_NONE;
      if (data_valid) begin
        min_next   = data_in;
        max_next   = data_in;
        count_next = CNT_ONE;
        sat_next   = (CNT_ONE == CNT_MAX);
      end else begin
        min_next   = '0;
        max_next   = '0;
        count_next = '0;
        sat_next   = 1'b0;
      end
    end else begin
      unique case (state_r)
        S_IDLE: begin
          if (finish) begin
            state_next = S_ERROR;
            err_next   = ERR_NO_START;
          end
        end
        S_READING: begin
          if (finish) begin
            // The sample presented alongside finish is dropped
            if (count_r == '0) begin
              state_next = S_ERROR;
              err_next   = ERR_EMPTY;
            end else begin
              state_next = S_DONE;
            end
          end else if (data_valid) begin
            if (count_r == '0) begin
              min_next = data_in;
              max_next = data_in;
            end else begin
              if (below_min) min_next = data_in;
              if (above_max) max_next = data_in;
            end
            if (count_r != CNT_MAX) count_next = cnt_plus;
            sat_next = sat_r | (cnt_plus == CNT_MAX);
          end
        end
        S_DONE:  ;
        S_ERROR: ;
        default: ;
      endcase
    end
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_r <= S_IDLE;
      min_r   <= '0;
      max_r   <= '0;
      count_r <= '0;
      sat_r   <= 1'b0;
      err_r   <= ERR_NONE;
    end else begin
      state_r <= state_next;
      min_r   <= min_next;
      max_r   <= max_next;
      count_r <= count_next;
      sat_r   <= sat_next;
      err_r   <= err_next;
    end
  end

  // Outputs come only from registers; the ERROR state masks the results
  assign min_out   = (state_r == S_ERROR) ? '0 : min_r;
  assign max_out   = (state_r == S_ERROR) ? '0 : max_r;
  assign count_out = (state_r == S_ERROR) ? '0 : count_r;
  assign range_out = max_ext - min_ext;
  assign cnt_sat   = sat_r;
  assign busy      = (state_r == S_READING);
  assign done      = (state_r == S_DONE);
  assign error     = (state_r == S_ERROR);
  assign err_code  = err_r;

endmodule

// File: tb/tb_range_tracker.sv
// Self-checking bench for range_tracker: directed scenarios plus a randomized
// run compared against a queue-based model of the accepted samples.
module tb_range_tracker;

  localparam int W    = 10;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          data_valid = 1'b0;
  logic          go = 1'b0;
  logic          finish = 1'b0;
  logic [W-1:0]  min_out;
  logic [W-1:0]  max_out;
  logic [W:0]    range_out;
  logic [CW-1:0] count_out;
  logic          cnt_sat;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  int tests  = 0;
  int failed = 0;

  // Reference model: mode 0 idle, 1 reading, 2 done, 3 error
  int m_mode  = 0;
  int m_code  = 0;
  int m_q[$];

  range_tracker #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .min_out(min_out), .max_out(max_out),
    .range_out(range_out), .count_out(count_out), .cnt_sat(cnt_sat),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  function automatic int val(input logic [W-1:0] d);
`ifdef RANGE_TRACKER_SIGNED_EN
    return int'($signed(d));
`else
    return int'(d);
`endif
  endfunction

  function automatic int q_min();
    int m;
    if (m_mode == 3 || m_q.size() == 0) return 0;
    m = m_q[0];
    foreach (m_q[i]) if (m_q[i] < m) m = m_q[i];
    return m;
  endfunction

  function automatic int q_max();
    int m;
    if (m_mode == 3 || m_q.size() == 0) return 0;
    m = m_q[0];
    foreach (m_q[i]) if (m_q[i] > m) m = m_q[i];
    return m;
  endfunction

  // One clock cycle of stimulus; the model follows the behavioural rules
  task automatic step(input bit g, input bit f, input bit v, input int d, input bit r);
    go = g; finish = f; data_valid = v; data_in = W'(d); reset = r;
    @(posedge clock);
    #1;
    if (r) begin
      m_mode = 0; m_code = 0; m_q.delete();
    end else if (g && !f) begin
      m_mode = 1; m_code = 0; m_q.delete();
      if (v) m_q.push_back(val(W'(d)));
    end else begin
      case (m_mode)
        0: if (f) begin m_mode = 3; m_code = 1; end
        1: begin
          if (f) begin
            if (m_q.size() == 0) begin m_mode = 3; m_code = 2; end
            else m_mode = 2;
          end else if (v) m_q.push_back(val(W'(d)));
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    tests++; if ({min_out, max_out} !== '0) begin failed++; $display("FAIL reset_minmax got %0d/%0d exp 0/0", min_out, max_out); end
    tests++; if (range_out !== '0) begin failed++; $display("FAIL reset_range got %0d exp 0", range_out); end
    tests++; if (count_out !== '0) begin failed++; $display("FAIL reset_count got %0d exp 0", count_out); end
    tests++; if ({cnt_sat, busy, done, error} !== 4'b0) begin failed++; $display("FAIL reset_flags got %b exp 0000", {cnt_sat, busy, done, error}); end
    tests++; if (err_code !== 2'b00) begin failed++; $display("FAIL reset_err got %b exp 00", err_code); end
  endtask

`ifndef RANGE_TRACKER_SIGNED_EN
  task automatic test_basic();
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 500, 0);
    step(0, 0, 1, 100, 0);
    step(0, 0, 1, 900, 0);
    step(0, 0, 1, 300, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i <= 10; i++) begin
      tests++; if (done !== 1'b1) begin failed++; $display("FAIL basic_done[%0d] got %b exp 1", i, done); end
      tests++; if (min_out !== 10'd100) begin failed++; $display("FAIL basic_min[%0d] got %0d exp 100", i, min_out); end
      tests++; if (max_out !== 10'd900) begin failed++; $display("FAIL basic_max[%0d] got %0d exp 900", i, max_out); end
      tests++; if (range_out !== 11'd800) begin failed++; $display("FAIL basic_range[%0d] got %0d exp 800", i, range_out); end
      tests++; if (count_out !== 3'd4) begin failed++; $display("FAIL basic_count[%0d] got %0d exp 4", i, count_out); end
      step(0, 0, 0, 0, 0);
    end
  endtask
`else
  task automatic test_signed();
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 'h200, 0);
    step(0, 0, 1, 'h1FF, 0);
    step(0, 0, 1, 'h000, 0);
    step(0, 1, 0, 0, 0);
    tests++; if (min_out !== 10'h200) begin failed++; $display("FAIL signed_min got %h exp 200", min_out); end
    tests++; if (max_out !== 10'h1FF) begin failed++; $display("FAIL signed_max got %h exp 1ff", max_out); end
    tests++; if (range_out !== 11'd1023) begin failed++; $display("FAIL signed_range got %0d exp 1023", range_out); end
    tests++; if (count_out !== 3'd3) begin failed++; $display("FAIL signed_count got %0d exp 3", count_out); end
  endtask
`endif

  task automatic test_qualifier();
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 200, 0);
    step(0, 0, 1, 400, 0);
    step(0, 0, 0, 1023, 0);
    step(0, 1, 1, 5, 0);
    tests++; if (done !== 1'b1) begin failed++; $display("FAIL qual_done got %b exp 1", done); end
    tests++; if (max_out !== 10'd400) begin failed++; $display("FAIL qual_max got %0d exp 400", max_out); end
    tests++; if (min_out !== 10'd200) begin failed++; $display("FAIL qual_min got %0d exp 200", min_out); end
    tests++; if (count_out !== 3'd2) begin failed++; $display("FAIL qual_count got %0d exp 2", count_out); end
  endtask

  task automatic test_no_start();
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 77, 0);
    tests++; if (error !== 1'b1 || err_code !== 2'b01) begin failed++; $display("FAIL nostart_err got %b/%b exp 1/01", error, err_code); end
    tests++; if ({min_out, max_out, range_out, count_out} !== '0) begin failed++; $display("FAIL nostart_zero got %0d/%0d/%0d/%0d exp 0", min_out, max_out, range_out, count_out); end
    step(0, 0, 1, 5, 0);
    tests++; if (error !== 1'b1 || err_code !== 2'b01) begin failed++; $display("FAIL nostart_hold got %b/%b exp 1/01", error, err_code); end
    step(1, 0, 0, 0, 0);
    tests++; if (busy !== 1'b1 || error !== 1'b0 || err_code !== 2'b00) begin failed++; $display("FAIL nostart_recover got %b/%b/%b exp 1/0/00", busy, error, err_code); end
  endtask

  task automatic test_empty();
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    tests++; if (busy !== 1'b1 || count_out !== '0 || range_out !== '0) begin failed++; $display("FAIL empty_start got %b/%0d/%0d exp 1/0/0", busy, count_out, range_out); end
    step(0, 1, 0, 0, 0);
    tests++; if (error !== 1'b1 || err_code !== 2'b10) begin failed++; $display("FAIL empty_err got %b/%b exp 1/10", error, err_code); end
  endtask

  task automatic test_restart_sat();
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 300, 0);
    for (int i = 1; i < 9; i++) begin
      step(0, 0, 1, 300 + i * 10, 0);
      if (i == 5) begin
        tests++; if (count_out !== 3'd6 || cnt_sat !== 1'b0) begin failed++; $display("FAIL sat_pre got %0d/%b exp 6/0", count_out, cnt_sat); end
      end
    end
    tests++; if (count_out !== 3'd7 || cnt_sat !== 1'b1) begin failed++; $display("FAIL sat_count got %0d/%b exp 7/1", count_out, cnt_sat); end
    tests++; if (max_out !== 10'd380 || min_out !== 10'd300) begin failed++; $display("FAIL sat_minmax got %0d/%0d exp 300/380", min_out, max_out); end
    step(1, 0, 1, 42, 0);
    tests++; if (count_out !== 3'd1 || cnt_sat !== 1'b0) begin failed++; $display("FAIL restart_count got %0d/%b exp 1/0", count_out, cnt_sat); end
    tests++; if (min_out !== 10'd42 || max_out !== 10'd42 || range_out !== '0) begin failed++; $display("FAIL restart_minmax got %0d/%0d/%0d exp 42/42/0", min_out, max_out, range_out); end
    step(0, 0, 1, 7, 1);
    tests++; if ({min_out, max_out, range_out, count_out, cnt_sat, busy, done, error, err_code} !== '0) begin failed++; $display("FAIL midrun_reset got %0d/%0d/%0d/%0d flags %b%b%b%b/%b exp all 0", min_out, max_out, range_out, count_out, cnt_sat, busy, done, error, err_code); end
  endtask

  task automatic test_random();
    int exp_min, exp_max, exp_cnt, d;
    bit g, f, v, r;
    step(0, 0, 0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      g = ($urandom_range(0, 99) < 6);
      f = ($urandom_range(0, 99) < 7);
      v = ($urandom_range(0, 99) < 65);
      r = ($urandom_range(0, 999) < 5);
      case ($urandom_range(0, 7))
        0: d = 0;
        1: d = (1 << W) - 1;
        2: d = (1 << (W - 1));
        3: d = (1 << (W - 1)) - 1;
        default: d = int'($urandom_range(0, (1 << W) - 1));
      endcase
      step(g, f, v, d, r);
      exp_min = q_min();
      exp_max = q_max();
      exp_cnt = (m_q.size() > CMAX) ? CMAX : m_q.size();
      tests++; if (min_out !== W'(exp_min)) begin failed++; $display("FAIL rand_min[%0d] got %h exp %h", c, min_out, W'(exp_min)); end
      tests++; if (max_out !== W'(exp_max)) begin failed++; $display("FAIL rand_max[%0d] got %h exp %h", c, max_out, W'(exp_max)); end
      tests++; if (range_out !== (W+1)'(exp_max - exp_min)) begin failed++; $display("FAIL rand_range[%0d] got %0d exp %0d", c, range_out, exp_max - exp_min); end
      tests++; if (count_out !== CW'(exp_cnt)) begin failed++; $display("FAIL rand_count[%0d] got %0d exp %0d", c, count_out, exp_cnt); end
      tests++; if (cnt_sat !== (m_q.size() >= CMAX)) begin failed++; $display("FAIL rand_sat[%0d] got %b exp %b", c, cnt_sat, m_q.size() >= CMAX); end
      tests++; if ({busy, done, error} !== {m_mode == 1, m_mode == 2, m_mode == 3}) begin failed++; $display("FAIL rand_state[%0d] got %b%b%b exp mode %0d", c, busy, done, error, m_mode); end
      tests++; if (err_code !== 2'(m_code)) begin failed++; $display("FAIL rand_err[%0d] got %b exp %0d", c, err_code, m_code); end
    end
  endtask

  initial begin
    test_reset();
`ifndef RANGE_TRACKER_SIGNED_EN
    test_basic();
`else
    test_signed();
`endif
    test_qualifier();
    test_no_start();
    test_empty();
    test_restart_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/range_tracker.md
Name: range_tracker

Overview:
- Parametrised successor to the single-channel min/max range finder.
- Tracks the minimum, maximum, range and sample count of a qualified data stream between a go command and a finish command.
- Adds over the previous generation:
  - a data_valid qualifier;
  - a saturating sample counter;
  - coded errors, including an empty-run check;
  - restart on go mid-run;
  - results that hold after the run ends.
- Sits between the chip input pins and the result/debug output mux.

Parameters:
- WIDTH, 10, data sample width in bits.
- CNT_WIDTH, 8, sample counter width in bits.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  sample value.
- data_valid  input  1  data_in is a sample this cycle.
- go  input  1  start or restart a run.
- finish  input  1  end the current run.
- min_out  output  WIDTH  smallest accepted sample of the current/last run.
- max_out  output  WIDTH  largest accepted sample of the current/last run.
- range_out  output  WIDTH+1  max_out minus min_out, unsigned.
- count_out  output  CNT_WIDTH  number of accepted samples, saturating.
- cnt_sat  output  1  count_out reached its maximum this run (sticky until next start).
- busy  output  1  state is READING.
- done  output  1  state is DONE; results are final.
- error  output  1  state is ERROR.
- err_code  output  2  00 none, 01 NO_START (finish without a run), 10 EMPTY (finish with zero samples).

Behaviour:
- Reset (synchronous, active-high, reset=1 at the clock edge) puts the block in state IDLE. Resulting outputs:
  - min_out, max_out, range_out, count_out = 0;
  - cnt_sat, busy, done, error = 0;
  - err_code = 00.
  - Reset overrides all other inputs, including mid-run.
- States: IDLE, READING, DONE, ERROR.
- start = go & ~finish & (state != READING), or go & ~finish & (state == READING) (restart).
- On start:
  - count cleared to 0 and cnt_sat cleared; next state is READING; err_code set to 00.
  - If data_valid is also 1 that cycle, data_in is taken as the first sample: min = max = data_in, count = 1.
- Sample acceptance in READING: a sample is accepted when data_valid=1, finish=0 and go=0.
  - First sample of a run (count==0): min = max = data_in.
  - Otherwise: min updates if data_in < min; max updates if data_in > max.
  - Equal values cause no change.
  - count increments by 1 and saturates at 2^CNT_WIDTH-1; cnt_sat=1 from the cycle the counter reaches that value.
- finish in READING (go ignored):
  - count>0: next state DONE. The sample presented in the finish cycle is not accepted.
  - count==0: next state ERROR, err_code=10.
- IDLE:
  - finish=1 (with or without go): next state ERROR, err_code=01.
  - start: next state READING.
  - otherwise: hold.
- DONE: min/max/count/cnt_sat hold indefinitely; start goes to READING; finish alone holds DONE.
- ERROR:
  - min_out, max_out, range_out, count_out read 0; error=1; err_code holds its value.
  - start goes to READING and clears err_code.
  - Any other input combination holds ERROR.
- Output timing:
  - All outputs are registered or derived only from registered state; there is no combinational input-to-output path.
  - Results reflect samples accepted up to the previous edge, i.e. latency is 1 cycle.
- range_out = max - min, computed in WIDTH+1 bits.
  - Read in IDLE: 0.
  - Read in READING with count==0: 0.

Optional Feature:
- Macro: RANGE_TRACKER_SIGNED_EN.
- Defined: data_in, min_out and max_out are two's complement and comparisons are signed. range_out = max - min computed as a (WIDTH+1)-bit signed difference, which is always non-negative and fits unsigned WIDTH+1 bits.
- Undefined: all values unsigned, and range_out's MSB is always 0.

Test Plan:
- Basic run, WIDTH=10: go+valid with 500, then valid 100, 900, 300, then finish → done=1, min_out=100, max_out=900, range_out=800, count_out=4; these values hold 10 further idle cycles.
- Qualifier and finish-cycle sample: during a run with samples 200, 400, present 1023 with data_valid=0, then present 5 with valid=1 together with finish → max_out=400, min_out=200, count_out=2.
- NO_START error: in IDLE, finish=1 → next cycle error=1, err_code=01, outputs 0. Then go=1, finish=0 → busy=1, error=0, err_code=00.
- EMPTY error: go with data_valid=0, then finish next cycle → error=1, err_code=10.
- Restart, saturation and reset:
  - CNT_WIDTH=3: 9 accepted samples → count_out=7, cnt_sat=1.
  - Then go mid-run with valid sample 42 → count_out=1, min_out=max_out=42, cnt_sat=0.
  - Then reset=1 for one cycle → all outputs 0, state IDLE.
- Signed (macro defined, WIDTH=10): samples 0x200 (-512), 0x1FF (511), 0x000 → min_out=0x200, max_out=0x1FF, range_out=1023.
